// File: rtl/lsu_mem_if.sv
// lsu_mem_if -- MEM-stage load/store executor.
//
// Takes the decoded memory op of the instruction sitting in MEM and runs it
// as one request/grant/response transaction on the data-memory bus. It
// builds byte enables and the lane-replicated store word, and it sign- or
// zero-extends load data. The pipeline is held until the op retires.
// Misaligned ops are rejected with a one-cycle flag and never reach the bus.
//
// Ports:
//   clk, rst_n       core clock; asynchronous active-low reset
//   lsu_valid        MEM-stage instruction valid (held while lsu_stall=1)
//   lsu_ctrl         decoded op, encoded as lsu_pkg::lsu_ctrl_e
//   lsu_addr         effective byte address
//   lsu_wdata        store data (rs2)
//   lsu_stall        hold pipeline (combinational)
//   lsu_done         one-cycle pulse: op retired
//   lsu_rdata        extended load result, updated only by load responses
//   lsu_misalign     one-cycle pulse: misaligned op rejected
//   lsu_err_store    qualifies lsu_misalign: 1=store, 0=load
//   dmem_*           data-memory bus (req/gnt handshake, one rvalid per grant)

package lsu_pkg;
  typedef enum logic [3:0] {
    LSU_NOP = 4'd0,
    LSU_LB  = 4'd1,
    LSU_LH  = 4'd2,
    LSU_LW  = 4'd3,
    LSU_LBU = 4'd4,
    LSU_LHU = 4'd5,
    LSU_SB  = 4'd6,
    LSU_SH  = 4'd7,
    LSU_SW  = 4'd8
  } lsu_ctrl_e;
endpackage

module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_valid,
  input  logic [3:0]            lsu_ctrl,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [31:0]           lsu_wdata,
  output logic                  lsu_stall,
  output logic                  lsu_done,
  output logic [31:0]           lsu_rdata,
  output logic                  lsu_misalign,
  output logic                  lsu_err_store,
  output logic                  dmem_req,
  input  logic                  dmem_gnt,
  output logic                  dmem_we,
  output logic [3:0]            dmem_be,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_rvalid,
  input  logic [31:0]           dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                state_q, state_d;
  lsu_ctrl_e             ctrl_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  done_q, misalign_q, err_store_q;

  lsu_ctrl_e ctrl_in;
  logic      active, accept, misaligned_in, store_in, retire;
  logic      load_q;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_fmt;

  assign ctrl_in  = lsu_ctrl_e'(lsu_ctrl);
  assign active   = lsu_valid && (ctrl_in != LSU_NOP);
  assign store_in = ctrl_in inside {LSU_SB, LSU_SH, LSU_SW};

  // The done/misalign pulse marks the cycle the pipeline is released; the
  // same instruction is still presented then and must not be accepted again.
  assign accept = (state_q == IDLE) && active && !done_q && !misalign_q;
  assign retire = (state_q == RESP) && dmem_rvalid;

  assign lsu_stall = active && !(done_q || misalign_q);

  // NOTE: every signal driven from an always_comb gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    misaligned_in = 1'b0;
    case (ctrl_in)
      LSU_LH, LSU_LHU, LSU_SH: misaligned_in = lsu_addr[0];
      LSU_LW, LSU_SW:          misaligned_in = |lsu_addr[1:0];
      default:                 misaligned_in = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !misaligned_in) state_d = REQ;
      REQ:     if (dmem_gnt)                 state_d = RESP;
      RESP:    if (dmem_rvalid)              state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Load result formatting from the captured byte offset.
  assign load_q = ctrl_q inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};

  always_comb begin
    byte_lane = dmem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: byte_lane = dmem_rdata[7:0];
      2'd1: byte_lane = dmem_rdata[15:8];
      2'd2: byte_lane = dmem_rdata[23:16];
      2'd3: byte_lane = dmem_rdata[31:24];
      default: byte_lane = dmem_rdata[7:0];
    endcase
    half_lane = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ctrl_q)
      LSU_LB:  load_fmt = {{24{byte_lane[7]}}, byte_lane};
      LSU_LBU: load_fmt = {24'h0, byte_lane};
      LSU_LH:  load_fmt = {{16{half_lane[15]}}, half_lane};
      LSU_LHU: load_fmt = {16'h0, half_lane};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= LSU_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      err_store_q <= 1'b0;
    end else begin
      if (accept && !misaligned_in) begin
        ctrl_q  <= ctrl_in;
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
      end
      misalign_q  <= accept && misaligned_in;
      err_store_q <= accept && misaligned_in && store_in;
      done_q      <= retire;
      if (retire && load_q) rdata_q <= load_fmt;
    end
  end

  // Bus drive: everything comes from the captured op, so it is stable for
  // the whole REQ phase and quiet (zero) otherwise.
  assign dmem_req = (state_q == REQ);

  always_comb begin
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (dmem_req) begin
      dmem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      case (ctrl_q)
        LSU_SB: begin
          dmem_we    = 1'b1;
          dmem_be    = 4'b0001 << addr_q[1:0];
          dmem_wdata = {4{wdata_q[7:0]}};
        end
        LSU_SH: begin
          dmem_we    = 1'b1;
          dmem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{wdata_q[15:0]}};
        end
        LSU_SW: begin
          dmem_we    = 1'b1;
          dmem_be    = 4'b1111;
          dmem_wdata = wdata_q;
        end
        default: begin
          dmem_we = 1'b0;
          dmem_be = 4'b1111;
        end
      endcase
    end
  end

  assign lsu_done      = done_q;
  assign lsu_misalign  = misalign_q;
  assign lsu_err_store = err_store_q;
  assign lsu_rdata     = rdata_q;

endmodule
